// File: rtl/perf_overflow_ctrl_pkg.sv
// rtl/perf_overflow_ctrl_pkg.sv - shared types, CSR addresses and helpers for perf_overflow_ctrl
//
// Purpose: XLEN-wide data type, the CSR addresses decoded by the overflow
// controller, the LCOFI interrupt FSM state encoding and the helper that
// maps a counter index to its mhpmevent CSR address.
package perf_overflow_ctrl_pkg;

    localparam int XLEN = 64;

    typedef logic [XLEN-1:0] xlen_t;

    // Counter 1 is mhpmcounter3, so its event-select CSR is mhpmevent3.
    localparam logic [11:0] CSR_MHPM_EVENT_3 = 12'h323;
    localparam logic [11:0] CSR_SCOUNTOVF    = 12'hDA0;

    typedef enum logic [1:0] {
        LCOFI_IDLE     = 2'd0,
        LCOFI_PEND     = 2'd1,
        LCOFI_SERVICED = 2'd2
    } lcofi_state_e;

    // Address of CSR_MHPM_EVENT_(idx+2) for generic counter idx (1-based).
    function automatic logic [11:0] mhpm_event_addr(input int idx);
        return CSR_MHPM_EVENT_3 + 12'(idx - 1);
    endfunction

endpackage

// File: rtl/perf_overflow_ctrl_if.sv
// rtl/perf_overflow_ctrl_if.sv - CSR access bus between csr_regfile and perf_overflow_ctrl
//
// Signals:
//   addr  - 12-bit CSR address
//   we    - CSR write enable
//   wdata - CSR write data (XLEN)
//   rdata - CSR read data (XLEN), combinational from addr
// Modports: master (CSR file side), slave (overflow controller side).
interface perf_overflow_ctrl_if;

    logic [11:0]                 addr;
    logic                        we;
    perf_overflow_ctrl_pkg::xlen_t wdata;
    perf_overflow_ctrl_pkg::xlen_t rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/perf_overflow_ctrl.sv
// rtl/perf_overflow_ctrl.sv - sticky HPM overflow flags, SCOUNTOVF/mhpmevent OF view and LCOFI request
//
// Purpose: watches the generic HPM counters for wrap events, keeps one sticky
// OF flag per counter, exposes the flags through mhpmevent[XLEN-1] and
// SCOUNTOVF, and raises the local counter-overflow interrupt request.
// Ports:
//   clk_i, rst_ni     - clock, asynchronous active-low reset
//   debug_mode_i      - overflows are not recorded while in debug mode
//   csr               - CSR bus (slave): addr/we/wdata in, rdata out
//   counter_q_i       - current counter values, counters 1..NumCounters
//   counter_inc_i     - per-counter increment strobe
//   mcountinhibit_i   - bit i+2 inhibits counter i
//   lcofie_i          - mie.LCOFIE
//   irq_ack_i         - interrupt taken pulse
//   lcofi_o           - interrupt request level
//   of_o              - sticky overflow flags
module perf_overflow_ctrl
    import perf_overflow_ctrl_pkg::*;
#(
    parameter int NumCounters = 6,
    parameter int CntWidth    = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 debug_mode_i,
    perf_overflow_ctrl_if.slave                  csr,
    input  logic [NumCounters:1][CntWidth-1:0]   counter_q_i,
    input  logic [NumCounters:1]                 counter_inc_i,
    input  logic [31:0]                          mcountinhibit_i,
    input  logic                                 lcofie_i,
    input  logic                                 irq_ack_i,
    output logic                                 lcofi_o,
    output logic [NumCounters:1]                 of_o
);

    logic [NumCounters:1] ovf;
    logic [NumCounters:1] wr_hit;
    logic [NumCounters:1] of_d;
    logic [NumCounters:1] of_q;
    logic                 new_of;
    lcofi_state_e         state_q;
    lcofi_state_e         state_d;

    // Only the OF bit of mhpmevent and the implemented inhibit bits matter here.
    logic unused_bits;
    assign unused_bits = ^{mcountinhibit_i[1:0], mcountinhibit_i[31:NumCounters+3],
                           csr.wdata[XLEN-2:0]};

    // An overflow is an increment of an all-ones counter that is not inhibited.
    // It takes priority over a same-cycle software write of the OF bit.
    always_comb begin
        ovf    = '0;
        wr_hit = '0;
        of_d   = of_q;
        for (int i = 1; i <= NumCounters; i++) begin
            ovf[i]    = counter_inc_i[i] & (&counter_q_i[i]) & ~mcountinhibit_i[i+2] & ~debug_mode_i;
            wr_hit[i] = csr.we & (csr.addr == mhpm_event_addr(i));
            of_d[i]   = ovf[i] | (wr_hit[i] ? csr.wdata[XLEN-1] : of_q[i]);
        end
    end

    // Pulses in the cycle whose edge will set a previously clear flag, so the
    // FSM enters PEND on the same edge the flag becomes visible.
    assign new_of = |(of_d & ~of_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            of_q <= '0;
        end else begin
            of_q <= of_d;
        end
    end

    assign of_o = of_q;

    always_comb begin
        csr.rdata = '0;
        if (csr.addr == CSR_SCOUNTOVF) begin
            csr.rdata[NumCounters+2:3] = of_q;
        end
        for (int i = 1; i <= NumCounters; i++) begin
            if (csr.addr == mhpm_event_addr(i)) begin
                csr.rdata[XLEN-1] = of_q[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= LCOFI_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new overflow while enabled always (re)arms the request, even against a
    // same-cycle acknowledge. Clearing every flag retires the request.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LCOFI_IDLE: begin
                if (new_of && lcofie_i) state_d = LCOFI_PEND;
            end
            LCOFI_PEND: begin
                if (new_of && lcofie_i) state_d = LCOFI_PEND;
                else if (of_d == '0)    state_d = LCOFI_IDLE;
                else if (irq_ack_i)     state_d = LCOFI_SERVICED;
            end
            LCOFI_SERVICED: begin
                if (new_of && lcofie_i) state_d = LCOFI_PEND;
                else if (of_d == '0)    state_d = LCOFI_IDLE;
            end
            default: state_d = LCOFI_IDLE;
        endcase
    end

    always_comb begin
        lcofi_o = (state_q == LCOFI_PEND);
    end

endmodule

// File: tb/tb_perf_overflow_ctrl.sv
// tb/tb_perf_overflow_ctrl.sv - self-checking bench for perf_overflow_ctrl
module tb_perf_overflow_ctrl;
    import perf_overflow_ctrl_pkg::*;

    localparam int NC = 6;
    localparam int CW = 64;

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   debug_mode;
    logic                   lcofie;
    logic                   irq_ack;
    logic                   lcofi;
    logic [NC:1][CW-1:0]    counter_q;
    logic [NC:1]            counter_inc;
    logic [NC:1]            of;
    logic [31:0]            mcountinhibit;

    perf_overflow_ctrl_if bus ();

    always #5 clk = ~clk;

    perf_overflow_ctrl #(
        .NumCounters (NC),
        .CntWidth    (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .debug_mode_i    (debug_mode),
        .csr             (bus),
        .counter_q_i     (counter_q),
        .counter_inc_i   (counter_inc),
        .mcountinhibit_i (mcountinhibit),
        .lcofie_i        (lcofie),
        .irq_ack_i       (irq_ack),
        .lcofi_o         (lcofi),
        .of_o            (of)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: the set of flagged counters and whether an interrupt is outstanding.
    bit [NC:1] m_of;
    bit        m_irq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] model_read(input logic [11:0] a);
        logic [63:0] r;
        r = '0;
        if (a == 12'hDA0) begin
            for (int i = 1; i <= NC; i++) r[i+2] = m_of[i];
        end else if (int'(a) >= 'h323 && int'(a) <= 'h322 + NC) begin
            r[63] = m_of[int'(a) - 'h322];
        end
        return r;
    endfunction

    task automatic model_next();
        bit [NC:1] nof;
        bit        ovf;
        bit        hit;
        for (int i = 1; i <= NC; i++) begin
            ovf = counter_inc[i] && (counter_q[i] == '1) && !mcountinhibit[i+2] && !debug_mode;
            hit = bus.we && (int'(bus.addr) == 'h322 + i);
            nof[i] = ovf ? 1'b1 : (hit ? bus.wdata[63] : m_of[i]);
        end
        if (((nof & ~m_of) != '0) && lcofie) m_irq = 1'b1;
        else if (nof == '0 || irq_ack)      m_irq = 1'b0;
        m_of = nof;
    endtask

    task automatic step();
        @(negedge clk);
        check("data_o", bus.rdata, model_read(bus.addr));
        model_next();
        @(posedge clk);
        #1;
        check("of_o", {58'd0, of}, {58'd0, m_of});
        check("lcofi_o", {63'd0, lcofi}, {63'd0, m_irq});
    endtask

    task automatic idle_inputs();
        counter_q     = '0;
        counter_inc   = '0;
        mcountinhibit = '0;
        debug_mode    = 1'b0;
        irq_ack       = 1'b0;
        bus.we        = 1'b0;
        bus.wdata     = '0;
    endtask

    initial begin
        idle_inputs();
        lcofie   = 1'b1;
        bus.addr = 12'hDA0;
        m_of     = '0;
        m_irq    = 1'b0;
        #3;
        check("rst_of", {58'd0, of}, 64'd0);
        check("rst_lcofi", {63'd0, lcofi}, 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        #9 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Counter 1 wraps with interrupts enabled.
        counter_q[1] = '1; counter_inc[1] = 1'b1;
        step();
        check("c1_of", {63'd0, of[1]}, 64'd1);
        check("c1_irq", {63'd0, lcofi}, 64'd1);

        // Acknowledge, then software clears the flag via mhpmevent3.
        idle_inputs(); irq_ack = 1'b1;
        step();
        check("ack_irq", {63'd0, lcofi}, 64'd0);
        idle_inputs(); bus.we = 1'b1; bus.addr = 12'h323; bus.wdata = '0;
        step();
        check("clr_of", {58'd0, of}, 64'd0);

        // Counters 2 and 5 in the same cycle.
        idle_inputs(); bus.addr = 12'hDA0;
        counter_q[2] = '1; counter_q[5] = '1; counter_inc = 6'b010010;
        step();
        check("scountovf_2_5", bus.rdata, 64'h90);
        check("c25_irq", {63'd0, lcofi}, 64'd1);
        idle_inputs(); bus.we = 1'b1; bus.addr = 12'h324;
        step();
        idle_inputs(); bus.we = 1'b1; bus.addr = 12'h327;
        step();
        check("clr25_of", {58'd0, of}, 64'd0);

        // Inhibited and debug-mode increments are not recorded.
        idle_inputs(); counter_q[2] = '1; counter_inc[2] = 1'b1; mcountinhibit[4] = 1'b1;
        step();
        check("inh_of", {58'd0, of}, 64'd0);
        idle_inputs(); counter_q[3] = '1; counter_inc[3] = 1'b1; debug_mode = 1'b1;
        step();
        check("dbg_of", {58'd0, of}, 64'd0);
        check("dbg_irq", {63'd0, lcofi}, 64'd0);

        // Overflow beats a same-cycle clearing write.
        idle_inputs(); counter_q[2] = '1; counter_inc[2] = 1'b1;
        bus.we = 1'b1; bus.addr = 12'h324; bus.wdata = '0;
        step();
        check("race_of", {63'd0, of[2]}, 64'd1);

        // Reset in PEND drops the request without a clock edge.
        idle_inputs(); bus.addr = 12'hDA0; counter_q[6] = '1; counter_inc[6] = 1'b1;
        step();
        check("pend_irq", {63'd0, lcofi}, 64'd1);
        idle_inputs();
        #2 rst_ni = 1'b0;
        #1;
        check("async_irq", {63'd0, lcofi}, 64'd0);
        check("async_rdata", bus.rdata, 64'd0);
        m_of = '0; m_irq = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Overflow while disabled is not reported later.
        idle_inputs(); lcofie = 1'b0; counter_q[1] = '1; counter_inc[1] = 1'b1;
        step();
        check("dis_irq", {63'd0, lcofi}, 64'd0);
        idle_inputs(); lcofie = 1'b1;
        step();
        check("late_en_irq", {63'd0, lcofi}, 64'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 1; i <= NC; i++)
                counter_q[i] = ($urandom_range(0, 2) == 0) ? '1 : {$urandom, $urandom};
            counter_inc   = 6'($urandom);
            mcountinhibit = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            debug_mode    = ($urandom_range(0, 9) == 0);
            lcofie        = ($urandom_range(0, 3) != 0);
            irq_ack       = ($urandom_range(0, 4) == 0);
            bus.we        = ($urandom_range(0, 2) == 0);
            bus.wdata     = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       bus.addr = 12'hDA0;
                1:       bus.addr = 12'($urandom);
                default: bus.addr = 12'(12'h322 + 12'($urandom_range(0, NC + 1)));
            endcase
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
